// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared blackjack rank encoding, card value helper and shoe types
package blackjack_pkg;

   localparam int NUM_RANKS = 13;
   localparam int CARD_W    = 6;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [3:0] RANK_A  = 4'd1;
   localparam logic [3:0] RANK_2  = 4'd2;
   localparam logic [3:0] RANK_3  = 4'd3;
   localparam logic [3:0] RANK_4  = 4'd4;
   localparam logic [3:0] RANK_5  = 4'd5;
   localparam logic [3:0] RANK_6  = 4'd6;
   localparam logic [3:0] RANK_7  = 4'd7;
   localparam logic [3:0] RANK_8  = 4'd8;
   localparam logic [3:0] RANK_9  = 4'd9;
   localparam logic [3:0] RANK_10 = 4'd10;
   localparam logic [3:0] RANK_J  = 4'd11;
   localparam logic [3:0] RANK_Q  = 4'd12;
   localparam logic [3:0] RANK_K  = 4'd13;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } shoe_state_e;

   // Ace counts high; picture cards count as ten.
   function automatic logic [CARD_W-1:0] rank_to_value(input logic [3:0] rank);
      if (rank == RANK_A) begin
         return 6'd11;
      end else if (rank >= RANK_10) begin
         return 6'd10;
      end else begin
         return {2'b00, rank};
      end
   endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// rtl/shoe_lfsr.sv - 16-bit Galois LFSR with seed load and zero-seed guard
module shoe_lfsr
   import blackjack_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_load_i,
   input  logic [15:0] seed_in_i,
   output logic [15:0] lfsr_o
);

   // An all-zero state would lock the LFSR, so zero seeds become 1.
   localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q, lfsr_d;

   // Seed load overrides the free-running shift.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      if (seed_load_i) begin
         lfsr_d = (seed_in_i == 16'h0000) ? 16'h0001 : seed_in_i;
      end
   end

   // State register, reloaded with the build-time seed on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED_SAFE;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - multi-deck card shoe dealing without replacement
module card_shoe
   import blackjack_pkg::*;
#(
   parameter int          NUM_DECKS = 1,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          CUT_LEVEL = 13,
   parameter int          CW        = $clog2(52*NUM_DECKS+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shoe_reload,
   input  logic              draw_req,
   input  logic              force_en,
   input  logic [3:0]        force_rank,
   input  logic              seed_load,
   input  logic [15:0]       seed_in,
   output logic              card_valid,
   output logic [3:0]        card_rank,
   output logic [CARD_W-1:0] card_value,
   output logic              busy,
   output logic              empty,
   output logic              low_shoe,
   output logic [CW-1:0]     remaining,
   output logic              draw_err
);

   localparam int            CNT_W    = $clog2(4*NUM_DECKS+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4*NUM_DECKS);
   localparam logic [CW-1:0] FULL_REM = CW'(52*NUM_DECKS);
   localparam logic [CW-1:0] CUT_Q    = CW'(CUT_LEVEL);

   shoe_state_e       state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  count_q [NUM_RANKS];
   logic [CNT_W-1:0]  count_d [NUM_RANKS];
   logic [CW-1:0]     remaining_q, remaining_d;
   logic              card_valid_q, card_valid_d;
   logic [3:0]        card_rank_q, card_rank_d;
   logic [CARD_W-1:0] card_value_q, card_value_d;
   logic              draw_err_q, draw_err_d;

   logic [15:0]       lfsr_w;
   logic              unused_lfsr;
   logic [3:0]        lfsr_rank;
   logic [3:0]        cand;
   logic              commit;
   logic [3:0]        commit_idx;

   shoe_lfsr #(.SEED(SEED)) u_lfsr (
      .clk         (clk),
      .rst_n       (reset),
      .seed_load_i (seed_load),
      .seed_in_i   (seed_in),
      .lfsr_o      (lfsr_w)
   );

   assign unused_lfsr = ^lfsr_w[15:4];

   // Candidate rank index: forced rank when legal, else LFSR nibble folded into 0..12.
   always_comb begin
      lfsr_rank = (lfsr_w[3:0] >= 4'd13) ? (lfsr_w[3:0] - 4'd13) : lfsr_w[3:0];
      cand      = lfsr_rank;
      if (force_en && (force_rank >= RANK_A) && (force_rank <= RANK_K)) begin
         cand = force_rank - 4'd1;
      end
   end

   // Next-state logic: reload, draw acceptance, circular search and commit.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      count_d      = count_q;
      remaining_d  = remaining_q;
      card_valid_d = 1'b0;
      card_rank_d  = card_rank_q;
      card_value_d = card_value_q;
      draw_err_d   = 1'b0;
      commit       = 1'b0;
      commit_idx   = cand;

      if (shoe_reload) begin
         for (int i = 0; i < NUM_RANKS; i++) begin
            count_d[i] = FULL_CNT;
         end
         remaining_d = FULL_REM;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (draw_req) begin
                  if (remaining_q == '0) begin
                     draw_err_d = 1'b1;
                  end else if (count_q[cand] != '0) begin
                     commit     = 1'b1;
                     commit_idx = cand;
                  end else begin
                     idx_d   = (cand == 4'd12) ? 4'd0 : cand + 4'd1;
                     state_d = ST_SEARCH;
                  end
               end
            end
            ST_SEARCH: begin
               if (count_q[idx_q] != '0) begin
                  commit     = 1'b1;
                  commit_idx = idx_q;
                  state_d    = ST_IDLE;
               end else begin
                  idx_d = (idx_q == 4'd12) ? 4'd0 : idx_q + 4'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // A committed rank is known non-empty, so remaining cannot underflow.
         if (commit) begin
            count_d[commit_idx] = count_q[commit_idx] - CNT_W'(1);
            remaining_d         = remaining_q - CW'(1);
            card_valid_d        = 1'b1;
            card_rank_d         = commit_idx + 4'd1;
            card_value_d        = rank_to_value(commit_idx + 4'd1);
         end
      end
   end

   // State and shoe contents, full shoe on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         for (int i = 0; i < NUM_RANKS; i++) begin
            count_q[i] <= FULL_CNT;
         end
         remaining_q  <= FULL_REM;
         card_valid_q <= 1'b0;
         card_rank_q  <= 4'd0;
         card_value_q <= '0;
         draw_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         count_q      <= count_d;
         remaining_q  <= remaining_d;
         card_valid_q <= card_valid_d;
         card_rank_q  <= card_rank_d;
         card_value_q <= card_value_d;
         draw_err_q   <= draw_err_d;
      end
   end

   assign card_valid = card_valid_q;
   assign card_rank  = card_rank_q;
   assign card_value = card_value_q;
   assign draw_err   = draw_err_q;
   assign remaining  = remaining_q;
   assign busy       = (state_q == ST_SEARCH);
   assign empty      = (remaining_q == '0);
   assign low_shoe   = (remaining_q < CUT_Q);

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - directed self-checking bench for card_shoe
module tb_card_shoe;

   logic        clk = 1'b0;
   logic        reset;
   logic        shoe_reload;
   logic        draw_req;
   logic        draw_req8;
   logic        force_en;
   logic [3:0]  force_rank;
   logic        seed_load;
   logic [15:0] seed_in;

   logic        card_valid, busy, empty, low_shoe, draw_err;
   logic [3:0]  card_rank;
   logic [5:0]  card_value;
   logic [5:0]  remaining;

   logic        card_valid8, busy8, empty8, low_shoe8, draw_err8;
   logic [3:0]  card_rank8;
   logic [5:0]  card_value8;
   logic [8:0]  remaining8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   card_shoe #(.NUM_DECKS(1)) dut (
      .clk(clk), .reset(reset), .shoe_reload(shoe_reload), .draw_req(draw_req),
      .force_en(force_en), .force_rank(force_rank), .seed_load(seed_load), .seed_in(seed_in),
      .card_valid(card_valid), .card_rank(card_rank), .card_value(card_value), .busy(busy),
      .empty(empty), .low_shoe(low_shoe), .remaining(remaining), .draw_err(draw_err)
   );

   card_shoe #(.NUM_DECKS(8)) dut8 (
      .clk(clk), .reset(reset), .shoe_reload(shoe_reload), .draw_req(draw_req8),
      .force_en(force_en), .force_rank(force_rank), .seed_load(seed_load), .seed_in(seed_in),
      .card_valid(card_valid8), .card_rank(card_rank8), .card_value(card_value8), .busy(busy8),
      .empty(empty8), .low_shoe(low_shoe8), .remaining(remaining8), .draw_err(draw_err8)
   );

   function automatic int ref_value(input int r);
      if (r == 1) return 11;
      if (r >= 10) return 10;
      return r;
   endfunction

   task automatic draw1(output logic [3:0] rank, output logic [5:0] val, output int lat);
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      lat = 1;
      while (card_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rank = card_rank;
      val  = card_value;
      checks++;
      if (lat >= 20) begin
         errors++;
         $display("FAIL draw_timeout: card_valid=%b after %0d cycles, required 1", card_valid, lat);
      end
   endtask

   task automatic draw8(output logic [3:0] rank, output int lat);
      @(negedge clk) draw_req8 = 1'b1;
      @(negedge clk) draw_req8 = 1'b0;
      lat = 1;
      while (card_valid8 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rank = card_rank8;
   endtask

   task automatic reload_shoe();
      @(negedge clk) shoe_reload = 1'b1;
      @(negedge clk) shoe_reload = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (remaining !== 6'd52) begin errors++; $display("FAIL reset_remaining: got %0d required 52", remaining); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b required 0", empty); end
      checks++; if (low_shoe !== 1'b0) begin errors++; $display("FAIL reset_low_shoe: got %b required 0", low_shoe); end
      checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL reset_card_valid: got %b required 0", card_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (draw_err !== 1'b0) begin errors++; $display("FAIL reset_draw_err: got %b required 0", draw_err); end
      checks++; if (remaining8 !== 9'd416) begin errors++; $display("FAIL reset_remaining8: got %0d required 416", remaining8); end
      reset = 1'b1;
   endtask

   task automatic test_force_draws();
      logic [3:0] ranks [4] = '{4'd10, 4'd8, 4'd4, 4'd1};
      int         vals  [4] = '{10, 8, 4, 11};
      int         rems  [4] = '{51, 50, 49, 48};
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      force_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         force_rank = ranks[i];
         draw1(r, v, lat);
         checks++; if (lat !== 1) begin errors++; $display("FAIL force_latency[%0d]: got %0d required 1", i, lat); end
         checks++; if (r !== ranks[i]) begin errors++; $display("FAIL force_rank[%0d]: got %0d required %0d", i, r, ranks[i]); end
         checks++; if (int'(v) !== vals[i]) begin errors++; $display("FAIL force_value[%0d]: got %0d required %0d", i, v, vals[i]); end
         checks++; if (int'(remaining) !== rems[i]) begin errors++; $display("FAIL force_remaining[%0d]: got %0d required %0d", i, remaining, rems[i]); end
      end
      @(negedge clk);
      checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b required 0", card_valid); end
      checks++; if (card_rank !== 4'd1) begin errors++; $display("FAIL rank_hold: got %0d required 1", card_rank); end
   endtask

   task automatic test_wrap();
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      force_en   = 1'b1;
      force_rank = 4'd13;
      for (int i = 0; i < 4; i++) begin
         draw1(r, v, lat);
         checks++; if (lat !== 1 || r !== 4'd13) begin errors++; $display("FAIL king_draw[%0d]: got rank %0d lat %0d required rank 13 lat 1", i, r, lat); end
      end
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      checks++; if (busy !== 1'b1 || card_valid !== 1'b0) begin errors++; $display("FAIL wrap_search: got busy %b valid %b required busy 1 valid 0", busy, card_valid); end
      @(negedge clk);
      checks++; if (card_valid !== 1'b1 || card_rank !== 4'd1 || card_value !== 6'd11) begin
         errors++; $display("FAIL wrap_card: got valid %b rank %0d value %0d required 1/1/11", card_valid, card_rank, card_value); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_end: got %b required 0", busy); end
      checks++; if (remaining !== 6'd43) begin errors++; $display("FAIL wrap_remaining: got %0d required 43", remaining); end
   endtask

   task automatic test_random_deal();
      int         hist [14];
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      int         exp_rem;
      for (int k = 0; k < 14; k++) hist[k] = 0;
      force_en = 1'b0;
      reload_shoe();
      for (int i = 0; i < 52; i++) begin
         draw1(r, v, lat);
         exp_rem = 51 - i;
         if (r >= 4'd1 && r <= 4'd13) hist[r]++;
         checks++; if (int'(v) !== ref_value(int'(r)) || r == 4'd0 || r > 4'd13) begin
            errors++; $display("FAIL deal_value[%0d]: got rank %0d value %0d required legal rank and value %0d", i, r, v, ref_value(int'(r))); end
         checks++; if (int'(remaining) !== exp_rem) begin errors++; $display("FAIL deal_remaining[%0d]: got %0d required %0d", i, remaining, exp_rem); end
         checks++; if (low_shoe !== (exp_rem < 13)) begin errors++; $display("FAIL deal_low_shoe[%0d]: got %b required %b", i, low_shoe, exp_rem < 13); end
         checks++; if (empty !== (exp_rem == 0)) begin errors++; $display("FAIL deal_empty[%0d]: got %b required %b", i, empty, exp_rem == 0); end
      end
      for (int k = 1; k <= 13; k++) begin
         checks++; if (hist[k] !== 4) begin errors++; $display("FAIL rank_histogram[%0d]: got %0d required 4", k, hist[k]); end
      end
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      checks++; if (draw_err !== 1'b1 || card_valid !== 1'b0) begin errors++; $display("FAIL empty_draw: got err %b valid %b required 1/0", draw_err, card_valid); end
      @(negedge clk);
      checks++; if (draw_err !== 1'b0 || card_valid !== 1'b0 || remaining !== 6'd0) begin
         errors++; $display("FAIL empty_after: got err %b valid %b rem %0d required 0/0/0", draw_err, card_valid, remaining); end
   endtask

   task automatic test_reload_search();
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      reload_shoe();
      force_en   = 1'b1;
      force_rank = 4'd13;
      for (int i = 0; i < 4; i++) draw1(r, v, lat);
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_pre_busy: got %b required 1", busy); end
      shoe_reload = 1'b1;
      @(negedge clk) shoe_reload = 1'b0;
      checks++; if (card_valid !== 1'b0 || remaining !== 6'd52 || busy !== 1'b0) begin
         errors++; $display("FAIL reload_abort: got valid %b rem %0d busy %b required 0/52/0", card_valid, remaining, busy); end
      @(negedge clk);
      checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL reload_abort_late: got %b required 0", card_valid); end
   endtask

   task automatic test_reload_with_draw();
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      force_en   = 1'b1;
      force_rank = 4'd5;
      draw1(r, v, lat);
      checks++; if (remaining !== 6'd51) begin errors++; $display("FAIL reload_draw_pre: got %0d required 51", remaining); end
      @(negedge clk) begin draw_req = 1'b1; shoe_reload = 1'b1; end
      @(negedge clk) begin draw_req = 1'b0; shoe_reload = 1'b0; end
      checks++; if (card_valid !== 1'b0 || remaining !== 6'd52) begin
         errors++; $display("FAIL reload_over_draw: got valid %b rem %0d required 0/52", card_valid, remaining); end
      @(negedge clk);
      checks++; if (card_valid !== 1'b0 || remaining !== 6'd52) begin
         errors++; $display("FAIL reload_over_draw_late: got valid %b rem %0d required 0/52", card_valid, remaining); end
   endtask

   task automatic run_seq(input logic [15:0] s, output logic [39:0] seq);
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      force_en = 1'b0;
      @(negedge clk) begin seed_in = s; seed_load = 1'b1; shoe_reload = 1'b1; end
      @(negedge clk) begin seed_load = 1'b0; shoe_reload = 1'b0; end
      for (int i = 0; i < 10; i++) begin
         draw1(r, v, lat);
         seq[i*4 +: 4] = r;
      end
   endtask

   task automatic test_seed();
      logic [39:0] seq_zero, seq_one, seq_a, seq_b;
      run_seq(16'h0000, seq_zero);
      run_seq(16'h0001, seq_one);
      run_seq(16'h1234, seq_a);
      run_seq(16'h1234, seq_b);
      checks++; if (seq_zero[3:0] !== 4'd1) begin errors++; $display("FAIL seed_one_first: got %0d required 1", seq_zero[3:0]); end
      checks++; if (seq_zero !== seq_one) begin errors++; $display("FAIL zero_seed_guard: got %h required %h", seq_zero, seq_one); end
      checks++; if (seq_a[3:0] !== 4'd11) begin errors++; $display("FAIL seed_1234_first: got %0d required 11", seq_a[3:0]); end
      checks++; if (seq_a !== seq_b) begin errors++; $display("FAIL seed_repeat: got %h required %h", seq_b, seq_a); end
   endtask

   task automatic test_reset_mid_search();
      logic [3:0] r;
      logic [5:0] v;
      int         lat;
      reload_shoe();
      force_en   = 1'b1;
      force_rank = 4'd13;
      for (int i = 0; i < 4; i++) draw1(r, v, lat);
      @(negedge clk) draw_req = 1'b1;
      @(negedge clk) draw_req = 1'b0;
      checks++; if (busy !== 1'b1 || remaining !== 6'd48) begin errors++; $display("FAIL mid_search_pre: got busy %b rem %0d required 1/48", busy, remaining); end
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || remaining !== 6'd52 || card_valid !== 1'b0 || card_rank !== 4'd0) begin
         errors++; $display("FAIL async_reset: got busy %b rem %0d valid %b rank %0d required 0/52/0/0", busy, remaining, card_valid, card_rank); end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_deck8();
      logic [3:0] r;
      int         lat;
      force_en   = 1'b1;
      force_rank = 4'd7;
      for (int i = 0; i < 32; i++) begin
         draw8(r, lat);
         checks++; if (lat !== 1 || r !== 4'd7) begin errors++; $display("FAIL deck8_draw[%0d]: got rank %0d lat %0d required 7/1", i, r, lat); end
      end
      draw8(r, lat);
      checks++; if (lat !== 2 || r !== 4'd8) begin errors++; $display("FAIL deck8_wrap: got rank %0d lat %0d required 8/2", r, lat); end
      checks++; if (remaining8 !== 9'd383) begin errors++; $display("FAIL deck8_remaining: got %0d required 383", remaining8); end
   endtask

   initial begin
      reset       = 1'b0;
      shoe_reload = 1'b0;
      draw_req    = 1'b0;
      draw_req8   = 1'b0;
      force_en    = 1'b0;
      force_rank  = 4'd0;
      seed_load   = 1'b0;
      seed_in     = 16'h0000;
      test_reset();
      test_force_draws();
      test_wrap();
      test_random_deal();
      test_reload_search();
      test_reload_with_draw();
      test_seed();
      test_reset_mid_search();
      test_deck8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
Parametrised multi-deck card source for the blackjack datapath. It is the successor to the fixed-script card_generation block and feeds player and dealer hands in top. It holds per-rank remaining counts for NUM_DECKS decks and deals without replacement, using a seeded LFSR. A force mode gives directed test sequences. It flags empty and low-shoe conditions so the game FSM can request a reshuffle.

Parameters:
NUM_DECKS, 1, decks in the shoe (1..8)
SEED, 16'hACE1, LFSR value loaded at reset (0 is replaced by 16'h0001)
CUT_LEVEL, 13, low_shoe asserts when remaining < CUT_LEVEL
CW, $clog2(52*NUM_DECKS+1), derived width of remaining

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; all state returns to reset values while low
shoe_reload  in  1  restore full shoe; priority over draw_req
draw_req  in  1  request one card; sampled only in IDLE
force_en  in  1  use force_rank instead of the LFSR for this draw
force_rank  in  4  forced rank, 1=A .. 13=K
seed_load  in  1  load LFSR from seed_in
seed_in  in  16  LFSR seed
card_valid  out  1  one-cycle pulse; card_rank and card_value are valid
card_rank  out  4  dealt rank 1..13, held until the next card
card_value  out  6  blackjack value: A=11, 2..10 face value, J/Q/K=10, held
busy  out  1  high while in SEARCH
empty  out  1  remaining == 0
low_shoe  out  1  remaining < CUT_LEVEL
remaining  out  CW  cards left in the shoe
draw_err  out  1  one-cycle pulse when draw_req is accepted while empty

Behaviour:
- Reset (reset low):
  - all 13 counts = 4*NUM_DECKS; remaining = 52*NUM_DECKS
  - lfsr = SEED; state = IDLE
  - card_valid, card_rank, card_value, busy, draw_err = 0
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle the block is out of reset.
  - seed_load overrides the advance; a seed_in of 0 loads 16'h0001.
- Candidate rank index r (0..12):
  - if force_en and 1 <= force_rank <= 13: r = force_rank-1
  - otherwise r = lfsr[3:0] mod 13 (13,14,15 map to 0,1,2)
- State machine, two states: IDLE and SEARCH.
  - IDLE, draw_req=1, empty=0:
    - if count[r] != 0: commit r.
    - else idx <= (r==12 ? 0 : r+1) and go to SEARCH.
  - IDLE, draw_req=1, empty=1: draw_err pulses next cycle; nothing else changes.
  - SEARCH, each cycle:
    - if count[idx] != 0: commit idx and go to IDLE.
    - else idx wraps 12 -> 0.
    - Termination is guaranteed because empty=0 at acceptance.
- Commit:
  - count[k] decrements; remaining decrements.
  - card_rank/card_value are registered; card_valid pulses the following cycle.
- Latency from draw_req to card_valid: 1 cycle when the candidate is available, up to 13 cycles worst case.
- Held draw_req: a new draw is accepted on each return to IDLE. The game FSM pulses draw_req for one cycle.
- shoe_reload (any state):
  - next cycle: counts full, remaining = 52*NUM_DECKS, state IDLE.
  - an in-flight SEARCH is aborted with no card_valid.
  - wins over draw_req in the same cycle; the LFSR is untouched.
- empty, low_shoe and busy are combinational from registers.
- remaining never underflows.

Decomposition:
- Shared blackjack_pkg:
  - rank encoding constants (RANK_A=1 .. RANK_K=13)
  - rank_to_value function
  - LFSR_TAPS, CARD_W=6
- One sub-module, shoe_lfsr: 16-bit Galois LFSR with seed load and zero-seed guard.
- Per-rank counters and the FSM live in card_shoe.

Test Plan:
- Reset, NUM_DECKS=1 -> remaining=52, empty=0, low_shoe=0, card_valid=0, busy=0.
- force_en=1; draw forced ranks 10, 8, 4, each as a one-cycle draw_req -> card_valid one cycle later each time; values 10, 8, 4; remaining 51, 50, 49. Then force_rank=1 -> value 11.
- Force rank 13 five times -> first four have latency 1. The fifth has latency 2 and returns rank 1 (A, wrap), with busy high for one cycle.
- 52 random draws -> each rank appears exactly 4 times; low_shoe rises when remaining becomes 12; empty=1 at 0. A 53rd draw_req -> draw_err pulse, no card_valid, remaining stays 0.
- shoe_reload cases:
  - asserted during SEARCH -> no card_valid; remaining=52 next cycle.
  - asserted with draw_req in the same cycle -> reload only, no card.
- Seed handling:
  - seed_load with seed_in=0 -> behaves as seed 1.
  - the same seed loaded twice gives identical 10-card sequences.
  - NUM_DECKS=8 -> remaining=416, rank count 32.
  - reset low mid-SEARCH -> immediate return to reset values.
